// File: rtl/bwt_mem_req_arbiter.sv
// Shares one BWT occurrence-memory request port between the forward and backward SMEM datapaths.
// Defining ARB_PRIO_BWD_EN gives the backward FIFO strict priority; the default is round-robin.
module bwt_mem_req_arbiter #(
    parameter int unsigned READ_NUM_WIDTH  = 10,
    parameter int unsigned ADDR_WIDTH      = 42,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned STALL_MARGIN    = 2,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_fwd_req_valid,
    input  logic [ADDR_WIDTH-1:0]     i_fwd_addr_k,
    input  logic [ADDR_WIDTH-1:0]     i_fwd_addr_l,
    input  logic [READ_NUM_WIDTH-1:0] i_fwd_read_num,
    input  logic                      i_bwd_req_valid,
    input  logic [ADDR_WIDTH-1:0]     i_bwd_addr_k,
    input  logic [ADDR_WIDTH-1:0]     i_bwd_addr_l,
    input  logic [READ_NUM_WIDTH-1:0] i_bwd_read_num,
    output logic                      o_fwd_stall,
    output logic                      o_bwd_stall,
    output logic                      o_mem_req_valid,
    input  logic                      i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr_k,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr_l,
    output logic [READ_NUM_WIDTH:0]   o_mem_req_tag,
    input  logic                      i_mem_rsp_valid,
    input  logic [READ_NUM_WIDTH:0]   i_mem_rsp_tag,
    output logic                      o_fwd_rsp_valid,
    output logic                      o_bwd_rsp_valid,
    output logic [READ_NUM_WIDTH-1:0] o_rsp_read_num,
    output logic [7:0]                o_outstanding,
    output logic [1:0]                o_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = 2 * ADDR_WIDTH + READ_NUM_WIDTH;
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] StallCnt = CntW'(FIFO_DEPTH - STALL_MARGIN);

    // Index 0 is the forward side, index 1 the backward side.
    logic [1:0]      w_push_v;
    logic [EntW-1:0] w_push_data [2];
    logic [EntW-1:0] w_head [2];
    logic [1:0]      w_nempty;
    logic [1:0]      w_stall;
    logic [1:0]      w_ovf;
    logic [1:0]      w_pop;

    logic            w_rr_bwd;
    logic            w_sel_bwd;
    logic            w_accept;
    logic [EntW-1:0] w_head_sel;
    logic            r_lock;
    logic            r_lock_bwd;
    logic            r_last_bwd;
    logic [EntW:0]   r_hold;
    logic [7:0]      r_outstanding;
    logic [1:0]      r_err;
    logic            r_fwd_rsp;
    logic            r_bwd_rsp;
    logic [READ_NUM_WIDTH-1:0] r_rsp_rn;

    assign w_push_v       = {i_bwd_req_valid, i_fwd_req_valid};
    assign w_push_data[0] = {i_fwd_addr_k, i_fwd_addr_l, i_fwd_read_num};
    assign w_push_data[1] = {i_bwd_addr_k, i_bwd_addr_l, i_bwd_read_num};

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        logic [EntW-1:0] r_mem [FIFO_DEPTH];
        logic [PtrW-1:0] r_wr_ptr;
        logic [PtrW-1:0] r_rd_ptr;
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_d;
        logic            r_stall;
        logic            w_full;
        logic            w_wr;
        logic            w_rd;

        assign w_full = (r_cnt == FullCnt);
        assign w_rd   = w_pop[s];
        // A full FIFO still accepts a write when its head leaves in the same cycle.
        assign w_wr   = w_push_v[s] && (!w_full || w_rd);
        assign w_ovf[s] = w_push_v[s] && w_full && !w_rd;

        always_comb begin
            w_cnt_d = r_cnt;
            case ({w_wr, w_rd})
                2'b10:   w_cnt_d = r_cnt + CntW'(1);
                2'b01:   w_cnt_d = r_cnt - CntW'(1);
                default: w_cnt_d = r_cnt;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
                r_stall  <= 1'b0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + PtrW'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + PtrW'(1);
                r_cnt   <= w_cnt_d;
                r_stall <= (w_cnt_d >= StallCnt);
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr) r_mem[r_wr_ptr] <= w_push_data[s];
        end

        assign w_head[s]   = r_mem[r_rd_ptr];
        assign w_nempty[s] = (r_cnt != '0);
        assign w_stall[s]  = r_stall;
    end

    always_comb begin
        w_rr_bwd = 1'b0;
`ifdef ARB_PRIO_BWD_EN
        w_rr_bwd = w_nempty[1];
`else
        if (w_nempty[0] && w_nempty[1]) begin
            w_rr_bwd = !r_last_bwd;
        end else begin
            w_rr_bwd = w_nempty[1];
        end
`endif
    end

    // A presented-but-unaccepted request keeps its side until the memory takes it.
    assign w_sel_bwd       = r_lock ? r_lock_bwd : w_rr_bwd;
    assign w_head_sel      = w_sel_bwd ? w_head[1] : w_head[0];
    assign o_mem_req_valid = (w_sel_bwd ? w_nempty[1] : w_nempty[0]) &&
                             (r_outstanding < 8'(MAX_OUTSTANDING));
    assign w_accept        = o_mem_req_valid && i_mem_req_ready;
    assign w_pop           = w_accept ? (w_sel_bwd ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        o_mem_addr_k  = r_hold[EntW-1 -: ADDR_WIDTH];
        o_mem_addr_l  = r_hold[READ_NUM_WIDTH +: ADDR_WIDTH];
        o_mem_req_tag = {r_hold[EntW], r_hold[READ_NUM_WIDTH-1:0]};
        if (|w_nempty) begin
            o_mem_addr_k  = w_head_sel[EntW-1 -: ADDR_WIDTH];
            o_mem_addr_l  = w_head_sel[READ_NUM_WIDTH +: ADDR_WIDTH];
            o_mem_req_tag = {w_sel_bwd, w_head_sel[READ_NUM_WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lock        <= 1'b0;
            r_lock_bwd    <= 1'b0;
            r_last_bwd    <= 1'b1;
            r_hold        <= '0;
            r_outstanding <= '0;
            r_err         <= '0;
            r_fwd_rsp     <= 1'b0;
            r_bwd_rsp     <= 1'b0;
            r_rsp_rn      <= '0;
        end else begin
            r_lock     <= o_mem_req_valid && !i_mem_req_ready;
            r_lock_bwd <= w_sel_bwd;
            if (w_accept) r_last_bwd <= w_sel_bwd;
            if (|w_nempty) r_hold <= {w_sel_bwd, w_head_sel};

            if (w_accept && !i_mem_rsp_valid) begin
                r_outstanding <= r_outstanding + 8'd1;
            end else if (!w_accept && i_mem_rsp_valid && (r_outstanding != 8'd0)) begin
                r_outstanding <= r_outstanding - 8'd1;
            end

            if (|w_ovf) r_err[0] <= 1'b1;
            if (i_mem_rsp_valid && (r_outstanding == 8'd0)) r_err[1] <= 1'b1;

            r_fwd_rsp <= i_mem_rsp_valid && !i_mem_rsp_tag[READ_NUM_WIDTH];
            r_bwd_rsp <= i_mem_rsp_valid && i_mem_rsp_tag[READ_NUM_WIDTH];
            if (i_mem_rsp_valid) r_rsp_rn <= i_mem_rsp_tag[READ_NUM_WIDTH-1:0];
        end
    end

    assign o_fwd_stall     = w_stall[0];
    assign o_bwd_stall     = w_stall[1];
    assign o_fwd_rsp_valid = r_fwd_rsp;
    assign o_bwd_rsp_valid = r_bwd_rsp;
    assign o_rsp_read_num  = r_rsp_rn;
    assign o_outstanding   = r_outstanding;
    assign o_err           = r_err;

endmodule
